// File: rtl/serial_pkg.sv
// Shared types and constants for the serial frame transmitter.
package serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Bit-period tick generator: pulses tick on the last clock of every bit period.
module bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic restart,
  input  logic en,
  output logic tick
);

  localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clr || restart) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + TW'(1);
    end
  end

  // Gated by en so a single-clock bit period does not tick while idle.
  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/serial_tx.sv
// Frame transmitter: start bit, WIDTH data bits LSB-first, optional parity, stop bit.
module serial_tx
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY       = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] data_in,
  output logic             load_ready,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BW = $clog2(WIDTH + 1);

  state_e           state;
  logic [WIDTH-1:0] shift_reg;
  logic [BW-1:0]    bit_cnt;
  logic             par_bit;
  logic             active;
  logic             tick;
  logic             last_stop;
  logic             accept;

  assign active     = (state != ST_IDLE);
  assign last_stop  = (state == ST_STOP) && tick;
  assign busy       = active;
  assign done       = last_stop;
  assign load_ready = (state == ST_IDLE) || last_stop;
  assign accept     = load_valid && load_ready;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk    (clk),
    .clr    (clr),
    .restart(accept),
    .en     (active),
    .tick   (tick)
  );

  // sout is registered and only updated at a bit-period boundary or on accept.
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= ST_IDLE;
      sout      <= LINE_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      par_bit   <= 1'b0;
    end else if (accept) begin
      state     <= ST_START;
      sout      <= 1'b0;
      shift_reg <= data_in;
      par_bit   <= (PARITY == PAR_ODD) ? ~^data_in : ^data_in;
    end else if (tick) begin
      case (state)
        ST_START: begin
          state     <= ST_DATA;
          bit_cnt   <= '0;
          sout      <= shift_reg[0];
          shift_reg <= shift_reg >> 1;
        end
        ST_DATA: begin
          if (bit_cnt == BW'(WIDTH - 1)) begin
            if (PARITY != PAR_NONE) begin
              state <= ST_PARITY;
              sout  <= par_bit;
            end else begin
              state <= ST_STOP;
              sout  <= LINE_IDLE;
            end
          end else begin
            bit_cnt   <= bit_cnt + BW'(1);
            sout      <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
          end
        end
        ST_PARITY: begin
          state <= ST_STOP;
          sout  <= LINE_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          sout  <= LINE_IDLE;
        end
      endcase
    end
  end

endmodule
